// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage MIPS pipeline.
// Runs the dcache request handshake, selects the writeback value and holds
// the MEM/WB register. Define MEM_PERF_CNT_EN to add access/stall counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; non-memory ops pass through in 1 cycle
// BUSY  | request registered on dmem*, waiting for dhit
module mem_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] rdat2_i,
    input  logic [WORD_W-1:0] imm_i,
    input  logic [WORD_W-1:0] pc4_i,
    input  logic [WORD_W-1:0] OutputPort_i,
    input  logic [REG_W-1:0]  wsel_i,
    input  logic              RegWr_i,
    input  logic              halt_i,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic [1:0]        MemToReg_i,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              stall_o,
    output logic [WORD_W-1:0] wdat_o,
    output logic [REG_W-1:0]  wsel_o,
    output logic              RegWr_o,
    output logic              halt_o
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]       mem_access_cnt,
    output logic [31:0]       mem_stall_cnt
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state;
    logic              access;
    logic [REG_W-1:0]  h_wsel;
    logic              h_regwr;
    logic              h_halt;
    logic [1:0]        h_m2r;
    logic [WORD_W-1:0] h_alu;
    logic [WORD_W-1:0] h_pc4;
    logic [WORD_W-1:0] h_imm;

    function automatic logic [WORD_W-1:0] wb_mux(
        input logic [1:0]        sel,
        input logic [WORD_W-1:0] alu,
        input logic [WORD_W-1:0] load,
        input logic [WORD_W-1:0] pc4,
        input logic [WORD_W-1:0] imm
    );
        case (sel)
            2'd0:    wb_mux = alu;
            2'd1:    wb_mux = load;
            2'd2:    wb_mux = pc4;
            default: wb_mux = imm;
        endcase
    endfunction

    assign access = (dREN_i | dWEN_i) & ~halt_o;

    // Stall while a request is being launched or is still waiting for dhit;
    // held low during reset so the hazard unit sees a clean pipeline.
    always_comb begin
        stall_o = 1'b0;
        if (!RST) begin
            if (state == IDLE)
                stall_o = access;
            else
                stall_o = ~dhit;
        end
    end

    // Handshake FSM, dcache request registers, instruction holding registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            dmemaddr  <= '0;
            dmemstore <= '0;
            h_wsel    <= '0;
            h_regwr   <= 1'b0;
            h_halt    <= 1'b0;
            h_m2r     <= 2'd0;
            h_alu     <= '0;
            h_pc4     <= '0;
            h_imm     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        dmemaddr  <= OutputPort_i;
                        dmemstore <= rdat2_i;
                        // a simultaneous load+store resolves to the store
                        dmemREN   <= dREN_i & ~dWEN_i;
                        dmemWEN   <= dWEN_i;
                        h_wsel    <= wsel_i;
                        h_regwr   <= RegWr_i;
                        h_halt    <= halt_i;
                        h_m2r     <= MemToReg_i;
                        h_alu     <= OutputPort_i;
                        h_pc4     <= pc4_i;
                        h_imm     <= imm_i;
                        state     <= BUSY;
                    end
                end
                default: begin
                    if (dhit) begin
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

    // MEM/WB register and sticky halt.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdat_o  <= '0;
            wsel_o  <= '0;
            RegWr_o <= 1'b0;
            halt_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        RegWr_o <= 1'b0;
                    end else begin
                        wdat_o  <= wb_mux(MemToReg_i, OutputPort_i, dmemload, pc4_i, imm_i);
                        wsel_o  <= wsel_i;
                        RegWr_o <= RegWr_i & ~halt_o;
                        if (halt_i)
                            halt_o <= 1'b1;
                    end
                end
                default: begin
                    if (dhit) begin
                        wdat_o  <= wb_mux(h_m2r, h_alu, dmemload, h_pc4, h_imm);
                        wsel_o  <= h_wsel;
                        RegWr_o <= h_regwr;
                        if (h_halt)
                            halt_o <= 1'b1;
                    end else begin
                        RegWr_o <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    // Saturating performance counters, frozen once the core has halted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_access_cnt <= '0;
            mem_stall_cnt  <= '0;
        end else if (!halt_o) begin
            if (state == BUSY && dhit && mem_access_cnt != 32'hFFFF_FFFF)
                mem_access_cnt <= mem_access_cnt + 32'd1;
            if (stall_o && mem_stall_cnt != 32'hFFFF_FFFF)
                mem_stall_cnt <= mem_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table of single-cycle ops, directed handshake
// sequences, and randomized ops checked against a transaction-level model.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] rdat2_i, imm_i, pc4_i, OutputPort_i, dmemload;
    logic [4:0]  wsel_i;
    logic        RegWr_i, halt_i, dREN_i, dWEN_i, dhit;
    logic [1:0]  MemToReg_i;
    logic        dmemREN, dmemWEN, stall_o, RegWr_o, halt_o;
    logic [31:0] dmemaddr, dmemstore, wdat_o;
    logic [4:0]  wsel_o;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] mem_access_cnt, mem_stall_cnt;
`endif

    mem_stage dut (
        .CLK(CLK), .RST(RST),
        .rdat2_i(rdat2_i), .imm_i(imm_i), .pc4_i(pc4_i),
        .OutputPort_i(OutputPort_i), .wsel_i(wsel_i), .RegWr_i(RegWr_i),
        .halt_i(halt_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
        .MemToReg_i(MemToReg_i), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .stall_o(stall_o), .wdat_o(wdat_o),
        .wsel_o(wsel_o), .RegWr_o(RegWr_o), .halt_o(halt_o)
`ifdef MEM_PERF_CNT_EN
        , .mem_access_cnt(mem_access_cnt), .mem_stall_cnt(mem_stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;
    bit model_halted = 1'b0;

    typedef struct {
        logic        ren;
        logic        wen;
        logic        halt;
        logic [1:0]  m2r;
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [31:0] load;
        logic [4:0]  wsel;
        logic        regwr;
    } op_t;

    typedef struct {
        logic [1:0]  m2r;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  wsel;
        logic        regwr;
        logic [31:0] exp_wdat;
        logic [4:0]  exp_wsel;
        logic        exp_regwr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        rdat2_i = '0; imm_i = '0; pc4_i = '0; OutputPort_i = '0;
        wsel_i = '0; RegWr_i = 0; halt_i = 0; dREN_i = 0; dWEN_i = 0;
        MemToReg_i = 2'd0; dhit = 0; dmemload = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wdat"}, wdat_o, 32'd0);
        chk({tag, "_wsel"}, {27'd0, wsel_o}, 32'd0);
        chk({tag, "_regwr"}, {31'd0, RegWr_o}, 32'd0);
        chk({tag, "_halt"}, {31'd0, halt_o}, 32'd0);
        chk({tag, "_dren"}, {31'd0, dmemREN}, 32'd0);
        chk({tag, "_dwen"}, {31'd0, dmemWEN}, 32'd0);
        chk({tag, "_daddr"}, dmemaddr, 32'd0);
        chk({tag, "_dstore"}, dmemstore, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    endtask

    // One instruction through MEM: the model decides whether it is an access,
    // how long the stall lasts (1 + delay cycles) and what lands in MEM/WB.
    task automatic run_op(input op_t op, input int delay);
        logic [31:0] src [4];
        logic        acc;
        logic        exp_regwr;
        src = '{op.alu, op.load, op.pc4, op.imm};
        acc = (op.ren | op.wen) & ~model_halted;
        rdat2_i = op.st; imm_i = op.imm; pc4_i = op.pc4; OutputPort_i = op.alu;
        wsel_i = op.wsel; RegWr_i = op.regwr; halt_i = op.halt;
        dREN_i = op.ren; dWEN_i = op.wen; MemToReg_i = op.m2r;
        dhit = 0; dmemload = op.load;
        #1;
        chk("stall_launch", {31'd0, stall_o}, {31'd0, acc});
        if (!acc) begin
            step();
            exp_regwr = op.regwr & ~model_halted;
            chk("wb_wdat", wdat_o, src[op.m2r]);
            chk("wb_wsel", {27'd0, wsel_o}, {27'd0, op.wsel});
            chk("wb_regwr", {31'd0, RegWr_o}, {31'd0, exp_regwr});
            chk("no_req_ren", {31'd0, dmemREN}, 32'd0);
            if (op.halt) model_halted = 1'b1;
        end else begin
            step();
            chk("req_ren", {31'd0, dmemREN}, {31'd0, op.ren & ~op.wen});
            chk("req_wen", {31'd0, dmemWEN}, {31'd0, op.wen});
            chk("req_addr", dmemaddr, op.alu);
            chk("req_store", dmemstore, op.st);
            chk("bubble_launch", {31'd0, RegWr_o}, 32'd0);
            for (int i = 0; i < delay; i++) begin
                dhit = 0;
                dmemload = $urandom;
                OutputPort_i = $urandom;
                #1;
                chk("stall_wait", {31'd0, stall_o}, 32'd1);
                step();
                chk("bubble_wait", {31'd0, RegWr_o}, 32'd0);
                chk("hold_addr", dmemaddr, op.alu);
                chk("hold_ren", {31'd0, dmemREN}, {31'd0, op.ren & ~op.wen});
            end
            dhit = 1;
            dmemload = op.load;
            #1;
            chk("stall_hit", {31'd0, stall_o}, 32'd0);
            step();
            dhit = 0;
            chk("done_wdat", wdat_o, src[op.m2r]);
            chk("done_wsel", {27'd0, wsel_o}, {27'd0, op.wsel});
            chk("done_regwr", {31'd0, RegWr_o}, {31'd0, op.regwr});
            chk("done_ren", {31'd0, dmemREN}, 32'd0);
            chk("done_wen", {31'd0, dmemWEN}, 32'd0);
            if (op.halt) model_halted = 1'b1;
        end
    endtask

    function automatic op_t alu_op(input logic [1:0] m2r, input logic [31:0] alu,
                                   input logic [4:0] wsel, input logic regwr);
        op_t o;
        o = '{ren: 0, wen: 0, halt: 0, m2r: m2r, alu: alu, st: 32'd0, pc4: 32'd0,
              imm: 32'd0, load: 32'd0, wsel: wsel, regwr: regwr};
        return o;
    endfunction

    initial begin
        vec_t vecs [5];
        op_t  op;

        clear_inputs();
        RST = 1;
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RST = 0;

        // Single-cycle writeback selection table.
        vecs[0] = '{2'd0, 32'h0000_0010, 32'h0,  32'h0,         5'd5,  1'b1, 32'h0000_0010, 5'd5,  1'b1};
        vecs[1] = '{2'd2, 32'h0000_1234, 32'h44, 32'h0,         5'd31, 1'b1, 32'h0000_0044, 5'd31, 1'b1};
        vecs[2] = '{2'd3, 32'h0000_1234, 32'h44, 32'hABCD_0000, 5'd7,  1'b1, 32'hABCD_0000, 5'd7,  1'b1};
        vecs[3] = '{2'd0, 32'hFFFF_FFFF, 32'h0,  32'h0,         5'd0,  1'b1, 32'hFFFF_FFFF, 5'd0,  1'b1};
        vecs[4] = '{2'd0, 32'h5555_AAAA, 32'h0,  32'h0,         5'd9,  1'b0, 32'h5555_AAAA, 5'd9,  1'b0};
        for (int i = 0; i < 5; i++) begin
            dREN_i = 0; dWEN_i = 0; halt_i = 0; dhit = 0;
            MemToReg_i = vecs[i].m2r; OutputPort_i = vecs[i].alu;
            pc4_i = vecs[i].pc4; imm_i = vecs[i].imm;
            wsel_i = vecs[i].wsel; RegWr_i = vecs[i].regwr;
            #1;
            chk("tbl_stall", {31'd0, stall_o}, 32'd0);
            step();
            chk("tbl_wdat", wdat_o, vecs[i].exp_wdat);
            chk("tbl_wsel", {27'd0, wsel_o}, {27'd0, vecs[i].exp_wsel});
            chk("tbl_regwr", {31'd0, RegWr_o}, {31'd0, vecs[i].exp_regwr});
        end

        // Load with three wait cycles: stall high for four cycles.
        op = '{ren: 1, wen: 0, halt: 0, m2r: 2'd1, alu: 32'h100, st: 32'h0, pc4: 32'h0,
               imm: 32'h0, load: 32'hDEAD_BEEF, wsel: 5'd8, regwr: 1};
        run_op(op, 3);

        // Store completing on the first BUSY cycle.
        op = '{ren: 0, wen: 1, halt: 0, m2r: 2'd0, alu: 32'h200, st: 32'hCAFE_0001, pc4: 32'h0,
               imm: 32'h0, load: 32'h0, wsel: 5'd3, regwr: 0};
        run_op(op, 0);

        // Load and store together: store wins.
        op = '{ren: 1, wen: 1, halt: 0, m2r: 2'd0, alu: 32'h300, st: 32'h1111_2222, pc4: 32'h0,
               imm: 32'h0, load: 32'h0, wsel: 5'd4, regwr: 0};
        run_op(op, 1);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            op.ren   = ($urandom_range(0, 2) == 0);
            op.wen   = ($urandom_range(0, 3) == 0);
            op.halt  = 0;
            op.m2r   = 2'($urandom_range(0, 3));
            op.alu   = $urandom;
            op.st    = $urandom;
            op.pc4   = $urandom;
            op.imm   = $urandom;
            op.load  = $urandom;
            op.wsel  = 5'($urandom_range(0, 31));
            op.regwr = 1'($urandom_range(0, 1));
            run_op(op, $urandom_range(0, 3));
        end

        // Halt riding on a load completes the load first.
        op = '{ren: 1, wen: 0, halt: 1, m2r: 2'd1, alu: 32'h400, st: 32'h0, pc4: 32'h0,
               imm: 32'h0, load: 32'h0BAD_F00D, wsel: 5'd2, regwr: 1};
        run_op(op, 1);
        chk("halt_after_access", {31'd0, halt_o}, 32'd1);

        // Once halted, a load starts nothing and writes nothing.
        op = '{ren: 1, wen: 0, halt: 0, m2r: 2'd1, alu: 32'h500, st: 32'h0, pc4: 32'h0,
               imm: 32'h0, load: 32'h0, wsel: 5'd6, regwr: 1};
        run_op(op, 0);
        clear_inputs();
        for (int i = 0; i < 3; i++) step();
        chk("halt_sticky", {31'd0, halt_o}, 32'd1);
        chk("halt_no_ren", {31'd0, dmemREN}, 32'd0);

        // Reset clears halt; plain halt sets it on the next edge.
        RST = 1; #1; RST = 0; model_halted = 0;
        chk("halt_reset", {31'd0, halt_o}, 32'd0);
        @(negedge CLK);
        op = alu_op(2'd0, 32'h0, 5'd0, 1'b0);
        op.halt = 1;
        run_op(op, 0);
        chk("halt_set", {31'd0, halt_o}, 32'd1);

        // Reset in the middle of a load aborts it immediately.
        RST = 1; #1; RST = 0; model_halted = 0;
        @(negedge CLK);
        rdat2_i = 32'h0; OutputPort_i = 32'h100; dREN_i = 1; MemToReg_i = 2'd1;
        RegWr_i = 1; wsel_i = 5'd9; dhit = 0;
        step();
        chk("busy_ren", {31'd0, dmemREN}, 32'd1);
        RST = 1;
        #1;
        check_all_zero("abort");
        @(negedge CLK);
        RST = 0;
        clear_inputs();
        run_op(alu_op(2'd0, 32'h0000_0010, 5'd5, 1'b1), 0);

        clear_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
